// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, state type and byte-enable helper for the FIFO read packer
package fifo_pkg;
    localparam int BW        = 8;
    localparam int MAX_BYTES = 8;

    typedef enum logic [1:0] {RUN, DRAIN, EMIT} pk_state_t;

    // Mask with the low n bits set; n ranges 0..MAX_BYTES.
    function automatic logic [MAX_BYTES-1:0] be_mask(input int unsigned n);
        logic [MAX_BYTES:0] m;
        m = ((MAX_BYTES+1)'(1) << n) - (MAX_BYTES+1)'(1);
        return m[MAX_BYTES-1:0];
    endfunction
endpackage

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - pops bytes from the FIFO and packs them little-endian into output words
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int BYTES = 4,
    parameter int BW    = fifo_pkg::BW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic                fifo_wr_active,
    input  logic [BW-1:0]       fifo_rdata,
    output logic                fifo_re,
    input  logic                flush,
    output logic                flush_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BYTES*BW-1:0] out_data,
    output logic [BYTES-1:0]    out_be
);
    localparam int            CW   = $clog2(BYTES + 1);
    localparam logic [CW-1:0] FULL = CW'(BYTES);

    pk_state_t            state;
    pk_state_t            state_next;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_cap;
    logic                 rd_pend;
    logic                 rd_fire;
    logic [BYTES*BW-1:0]  acc;
    logic [BYTES*BW-1:0]  acc_cap;
    logic                 slot_free;
    logic                 word_load;
    logic                 emit_load;
    logic                 flush_done_next;
    logic                 run_reads;
    logic [MAX_BYTES-1:0] be_part;

    // Count including the byte landing this cycle, so a full word can leave in its fill cycle.
    assign cnt_cap   = cnt + CW'(rd_pend);
    assign slot_free = !out_valid || out_ready;
    assign word_load = (cnt_cap == FULL) && slot_free;
    assign be_part   = be_mask(32'(cnt));

    // Reads only when the accumulator has room for the byte in flight plus this one.
    assign fifo_re = rst && run_reads && !fifo_empty && (cnt_cap < FULL);
    // The FIFO drops a read that collides with an accepted write, so such a read is retried.
    assign rd_fire = fifo_re && !fifo_empty && !fifo_wr_active;

    // Merge the returning byte into lane cnt.
    always_comb begin
        acc_cap = acc;
        for (int i = 0; i < BYTES; i++) begin
            if (rd_pend && cnt == CW'(i)) begin
                acc_cap[i*BW +: BW] = fifo_rdata;
            end
        end
    end

    // Flush sequencing: stop reading, let the in-flight byte and full words settle, then emit the remainder.
    always_comb begin
        state_next      = state;
        flush_done_next = 1'b0;
        emit_load       = 1'b0;
        run_reads       = 1'b0;
        case (state)
            RUN: begin
                run_reads = 1'b1;
                if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_pend && cnt < FULL) begin
                    if (cnt == '0) begin
                        flush_done_next = 1'b1;
                        state_next      = RUN;
                    end else begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                if (slot_free) begin
                    emit_load       = 1'b1;
                    flush_done_next = 1'b1;
                    state_next      = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator and output register; acc is cleared on every load so unused lanes of a partial word read 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            rd_pend    <= 1'b0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_be     <= '0;
            flush_done <= 1'b0;
        end else begin
            rd_pend    <= rd_fire;
            flush_done <= flush_done_next;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (word_load) begin
                out_data  <= acc_cap;
                out_be    <= '1;
                out_valid <= 1'b1;
                cnt       <= '0;
                acc       <= '0;
            end else if (emit_load) begin
                out_data  <= acc;
                out_be    <= be_part[BYTES-1:0];
                out_valid <= 1'b1;
                cnt       <= '0;
                acc       <= '0;
            end else begin
                cnt <= cnt_cap;
                acc <= acc_cap;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    localparam int BYTES = 4;
    localparam int W     = BYTES * BW;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic             fifo_wr_active;
    logic [BW-1:0]    fifo_rdata;
    logic             fifo_re;
    logic             flush;
    logic             flush_done;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [BYTES-1:0] out_be;

    fifo_rd_packer #(.BYTES(BYTES), .BW(BW)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_wr_active(fifo_wr_active),
        .fifo_rdata(fifo_rdata), .fifo_re(fifo_re), .flush(flush), .flush_done(flush_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_be(out_be)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [31:0]     bytes_in;
        bit              do_flush;
        logic [31:0]     exp_data;
        logic [3:0]      exp_be;
    } vec_t;

    int total = 0;
    int bad   = 0;

    byte unsigned src[$];
    byte unsigned popq[$];
    bit           hold_empty;
    int           cyc = 0;

    logic             fire_l, acc_l, fd_l, re_l;
    logic [W-1:0]     acc_data;
    logic [BYTES-1:0] acc_be;
    logic             prev_stall = 1'b0;
    logic [W-1:0]     prev_data;
    logic [BYTES-1:0] prev_be;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accepted words must carry the popped byte stream in order, lanes above the enable run zero.
    task automatic scoreboard();
        int               k;
        logic [W-1:0]     exp_w;
        logic [BYTES-1:0] exp_be;
        bit               under;
        k      = $countones(acc_be);
        exp_be = BYTES'((1 << k) - 1);
        exp_w  = '0;
        under  = 0;
        for (int i = 0; i < k; i++) begin
            if (popq.size() > 0) exp_w[8*i +: 8] = popq.pop_front();
            else under = 1;
        end
        check("sb_nonempty", 64'(k == 0), 64'(0));
        check("sb_underflow", 64'(under), 64'(0));
        check("sb_be", 64'(acc_be), 64'(exp_be));
        check("sb_data", 64'(acc_data), 64'(exp_w));
    endtask

    // One clock: caller sets inputs at negedge; FIFO model pops on an accepted read.
    task automatic cycle();
        fifo_empty = hold_empty || (src.size() == 0);
        #1;
        re_l     = fifo_re;
        fire_l   = fifo_re && !fifo_empty && !fifo_wr_active;
        acc_l    = out_valid && out_ready;
        acc_data = out_data;
        acc_be   = out_be;
        fd_l     = flush_done;
        if (rst && prev_stall)
            check("hold_stable", 64'({out_valid, out_data, out_be}), 64'({1'b1, prev_data, prev_be}));
        prev_stall = rst && out_valid && !out_ready;
        prev_data  = out_data;
        prev_be    = out_be;
        if (rst && acc_l) scoreboard();
        @(posedge clk);
        #1;
        cyc++;
        if (fire_l) begin
            fifo_rdata = src.pop_front();
            popq.push_back(fifo_rdata);
        end else begin
            fifo_rdata = BW'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic wait_word(input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            cycle();
            if (acc_l) ok = 1;
        end
        check("wait_word", 64'(ok), 64'(1));
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        logic [W-1:0] wd[2];
        int           wc[2];
        int           nw;
        int           nfd, nval;

        vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
        vecs[1] = '{4, 32'h88776655, 1'b0, 32'h88776655, 4'hF};
        vecs[2] = '{3, 32'h00A3A2A1, 1'b1, 32'h00A3A2A1, 4'h7};
        vecs[3] = '{1, 32'h000000C5, 1'b1, 32'h000000C5, 4'h1};
        vecs[4] = '{2, 32'h0000D2D1, 1'b1, 32'h0000D2D1, 4'h3};

        rst = 1'b0; flush = 1'b0; out_ready = 1'b1; fifo_wr_active = 1'b0;
        hold_empty = 1'b0; fifo_rdata = '0; fifo_empty = 1'b0;
        src = '{8'h01, 8'h02, 8'h03};
        @(negedge clk);

        // Reset held with a non-empty FIFO.
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst_re", 64'(fifo_re), 64'(0));
            check("rst_valid", 64'(out_valid), 64'(0));
            check("rst_data", 64'(out_data), 64'(0));
            check("rst_fd", 64'(flush_done), 64'(0));
        end
        src.delete();
        rst = 1'b1;
        cycle();

        // Streaming throughput: two words, loads five cycles apart.
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        nw = 0;
        for (int i = 0; i < 30 && nw < 2; i++) begin
            cycle();
            if (acc_l) begin
                wd[nw] = acc_data;
                wc[nw] = cyc;
                nw++;
            end
        end
        check("tp_words", 64'(nw), 64'(2));
        if (nw == 2) begin
            check("tp_word0", 64'(wd[0]), 64'(32'h44332211));
            check("tp_word1", 64'(wd[1]), 64'(32'h88776655));
            check("tp_spacing", 64'(wc[1] - wc[0]), 64'(5));
        end

        // Backpressure: first word held, accumulator full stalls the FIFO.
        out_ready = 1'b0;
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        repeat (14) cycle();
        check("bp_valid", 64'(out_valid), 64'(1));
        check("bp_data", 64'(out_data), 64'(32'h44332211));
        check("bp_fifo_nonempty", 64'(fifo_empty), 64'(0));
        check("bp_re", 64'(fifo_re), 64'(0));
        out_ready = 1'b1;
        cycle();
        check("bp_accept0", 64'({acc_l, acc_data}), 64'({1'b1, 32'h44332211}));
        check("bp_next_load", 64'({out_valid, out_data}), 64'({1'b1, 32'h88776655}));
        cycle();
        repeat (3) cycle();
        pulse_flush();
        wait_word(10);
        check("bp_tail", 64'({acc_data, acc_be, fd_l}), 64'({32'h00000099, 4'h1, 1'b1}));

        // Table of packed words, with and without flush.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) src.push_back(vecs[v].bytes_in[8*i +: 8]);
            if (vecs[v].do_flush) begin
                repeat (vecs[v].n + 3) cycle();
                pulse_flush();
            end
            wait_word(20);
            check($sformatf("vec%0d_data", v), 64'(acc_data), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d_be", v), 64'(acc_be), 64'(vecs[v].exp_be));
            check($sformatf("vec%0d_fd", v), 64'(fd_l), 64'(vecs[v].do_flush));
        end

        // Flush with an empty accumulator: done pulse, no word.
        pulse_flush();
        nfd = 0; nval = 0;
        repeat (6) begin
            cycle();
            if (fd_l) nfd++;
            if (acc_l) nval++;
        end
        check("empty_flush_fd", 64'(nfd), 64'(1));
        check("empty_flush_words", 64'(nval), 64'(0));

        // Read colliding with an accepted write is retried.
        src = '{8'hC1};
        fifo_wr_active = 1'b1;
        repeat (2) begin
            cycle();
            check("wr_re_held", 64'(re_l), 64'(1));
        end
        fifo_wr_active = 1'b0;
        cycle();
        check("wr_retry_fire", 64'(fire_l), 64'(1));
        repeat (3) cycle();
        pulse_flush();
        wait_word(10);
        check("wr_word", 64'({acc_data, acc_be}), 64'({32'h000000C1, 4'h1}));

        // Reset in the middle of a word discards the partial bytes.
        src = '{8'hE1, 8'hE2};
        repeat (5) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        check("midrst_valid", 64'(out_valid), 64'(0));
        rst = 1'b1;
        popq.delete();
        src = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        wait_word(20);
        check("midrst_word", 64'({acc_data, acc_be}), 64'({32'hB4B3B2B1, 4'hF}));

        // Random traffic against the byte-stream scoreboard.
        for (int i = 0; i < 400; i++) begin
            if (src.size() < 4) repeat (4) src.push_back(8'($urandom));
            hold_empty     = ($urandom_range(0, 9) < 3);
            fifo_wr_active = ($urandom_range(0, 9) < 2);
            out_ready      = ($urandom_range(0, 9) < 7);
            flush          = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush = 1'b0; fifo_wr_active = 1'b0; out_ready = 1'b1; hold_empty = 1'b1;
        repeat (8) cycle();
        pulse_flush();
        repeat (20) cycle();
        check("drain_empty", 64'(popq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
